// File: rtl/status_reg.sv
// 6502 processor status register (P) with the decimal-mode correction sequencer
// that drives the BCD correction constant into the ALU during the ADC/SBC adjust pass.
module status_reg #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    input  logic       alu_hc,
    input  logic       alu_dhc,
    input  logic       alu_dc,
    input  logic [7:0] db,
    input  logic [3:0] upd,
    input  logic       b_in,
    input  logic       dec_go,
    input  logic       sub,
    output logic [7:0] P,
    output logic [7:0] adj,
    output logic       adj_busy,
    output logic       D
);

    typedef enum logic {
        IDLE = 1'b0,
        ADJ  = 1'b1
    } state_t;

    localparam logic [3:0] UPD_NZ   = 4'd1;
    localparam logic [3:0] UPD_NZC  = 4'd2;
    localparam logic [3:0] UPD_NZCV = 4'd3;
    localparam logic [3:0] UPD_BIT  = 4'd4;
    localparam logic [3:0] UPD_PLP  = 4'd5;
    localparam logic [3:0] UPD_CLC  = 4'd6;
    localparam logic [3:0] UPD_SEC  = 4'd7;
    localparam logic [3:0] UPD_CLI  = 4'd8;
    localparam logic [3:0] UPD_SEI  = 4'd9;
    localparam logic [3:0] UPD_CLD  = 4'd10;
    localparam logic [3:0] UPD_SED  = 4'd11;
    localparam logic [3:0] UPD_CLV  = 4'd12;

    state_t     state, state_nxt;
    logic       n_q, v_q, d_q, i_q, z_q, c_q;
    logic       n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;
    logic       cf_q, cf_nxt;
    logic [7:0] adj_q, adj_nxt;

    // Nibble/byte correction requests seen at the end of the binary pass.
    logic dec_lo, dec_hi, dec_cf;

    assign dec_lo = sub ? ~alu_hc : (alu_dhc | alu_hc);
    assign dec_hi = sub ? ~alu_c  : (alu_dc  | alu_c);
    assign dec_cf = sub ? alu_c   : dec_hi;

    function automatic logic [7:0] adj_const(input logic is_sub, input logic hi, input logic lo);
        logic [7:0] k;
        if (is_sub) begin
            case ({hi, lo})
                2'b00:   k = 8'h00;
                2'b01:   k = 8'hFA;
                2'b10:   k = 8'hA0;
                default: k = 8'h9A;
            endcase
        end else begin
            k = {(hi ? 4'h6 : 4'h0), (lo ? 4'h6 : 4'h0)};
        end
        return k;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        n_nxt     = n_q;
        v_nxt     = v_q;
        d_nxt     = d_q;
        i_nxt     = i_q;
        z_nxt     = z_q;
        c_nxt     = c_q;
        cf_nxt    = cf_q;
        adj_nxt   = 8'h00;

        case (upd)
            UPD_NZ: begin
                n_nxt = alu_n;
                z_nxt = alu_z;
            end
            UPD_NZC: begin
                n_nxt = alu_n;
                z_nxt = alu_z;
                c_nxt = alu_c;
            end
            UPD_NZCV: begin
                n_nxt = alu_n;
                z_nxt = alu_z;
                c_nxt = alu_c;
                v_nxt = alu_v;
            end
            UPD_BIT: begin
                n_nxt = db[7];
                v_nxt = db[6];
                z_nxt = alu_z;
            end
            UPD_PLP: begin
                n_nxt = db[7];
                v_nxt = db[6];
                d_nxt = db[3];
                i_nxt = db[2];
                z_nxt = db[1];
                c_nxt = db[0];
            end
            UPD_CLC: c_nxt = 1'b0;
            UPD_SEC: c_nxt = 1'b1;
            UPD_CLI: i_nxt = 1'b0;
            UPD_SEI: i_nxt = 1'b1;
            UPD_CLD: d_nxt = 1'b0;
            UPD_SED: d_nxt = 1'b1;
            UPD_CLV: v_nxt = 1'b0;
            default: ;
        endcase

        // Sequencer looks at the stored D, so a same-edge PLP/SED/CLD cannot change this decision.
        case (state)
            IDLE: begin
                if (dec_go && d_q) begin
                    state_nxt = ADJ;
                    cf_nxt    = dec_cf;
                    adj_nxt   = adj_const(sub, dec_hi, dec_lo);
                end
            end
            ADJ: begin
                state_nxt = IDLE;
                c_nxt     = cf_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n_q   <= RESET_P[7];
            v_q   <= RESET_P[6];
            d_q   <= RESET_P[3];
            i_q   <= RESET_P[2];
            z_q   <= RESET_P[1];
            c_q   <= RESET_P[0];
            // NOTE: cf_q is a single control register, not a memory, so it is reset along with the rest.
            cf_q  <= 1'b0;
            adj_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            state <= state_nxt;
            n_q   <= n_nxt;
            v_q   <= v_nxt;
            d_q   <= d_nxt;
            i_q   <= i_nxt;
            z_q   <= z_nxt;
            c_q   <= c_nxt;
            cf_q  <= cf_nxt;
            adj_q <= adj_nxt;
        end
    end

    assign P        = {n_q, v_q, 1'b1, b_in, d_q, i_q, z_q, c_q};
    assign adj      = adj_q;
    assign adj_busy = (state == ADJ);
    assign D        = d_q;

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed decimal-mode scenarios plus
// randomized traffic compared against a byte-level reference model.
module tb_status_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_c, alu_n, alu_z, alu_v, alu_hc, alu_dhc, alu_dc;
    logic [7:0] db;
    logic [3:0] upd;
    logic       b_in, dec_go, sub;
    logic [7:0] p_out, adj_out;
    logic       busy, d_out;

    int errors = 0;
    int checks = 0;

    // Reference model: P as a byte, plus pending adjust-pass state.
    logic [7:0] m_p;
    logic       m_busy;
    logic [7:0] m_adj;
    logic       m_cf;

    status_reg #(.RESET_P(8'h34)) dut (
        .clk(clk), .reset(reset),
        .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .alu_hc(alu_hc), .alu_dhc(alu_dhc), .alu_dc(alu_dc),
        .db(db), .upd(upd), .b_in(b_in), .dec_go(dec_go), .sub(sub),
        .P(p_out), .adj(adj_out), .adj_busy(busy), .D(d_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_p();
        return {m_p[7:6], 1'b1, b_in, m_p[3:0]};
    endfunction

    task automatic model_edge();
        logic       old_d, was_busy, lo, hi;
        logic [8:0] sum;
        if (reset) begin
            m_p = 8'h34; m_busy = 1'b0; m_adj = 8'h00; m_cf = 1'b0;
            return;
        end
        old_d    = m_p[3];
        was_busy = m_busy;
        case (upd)
            4'd1:  begin m_p[7] = alu_n; m_p[1] = alu_z; end
            4'd2:  begin m_p[7] = alu_n; m_p[1] = alu_z; m_p[0] = alu_c; end
            4'd3:  begin m_p[7] = alu_n; m_p[1] = alu_z; m_p[0] = alu_c; m_p[6] = alu_v; end
            4'd4:  begin m_p[7] = db[7]; m_p[6] = db[6]; m_p[1] = alu_z; end
            4'd5:  m_p = db;
            4'd6:  m_p[0] = 1'b0;
            4'd7:  m_p[0] = 1'b1;
            4'd8:  m_p[2] = 1'b0;
            4'd9:  m_p[2] = 1'b1;
            4'd10: m_p[3] = 1'b0;
            4'd11: m_p[3] = 1'b1;
            4'd12: m_p[6] = 1'b0;
            default: ;
        endcase
        m_adj = 8'h00;
        if (was_busy) begin
            m_p[0] = m_cf;
            m_busy = 1'b0;
        end else if (dec_go && old_d) begin
            if (sub) begin
                lo = ~alu_hc; hi = ~alu_c; m_cf = alu_c;
                sum = (hi ? 9'h0A0 : 9'h000) + (lo ? 9'h0FA : 9'h000);
            end else begin
                lo = alu_dhc | alu_hc; hi = alu_dc | alu_c; m_cf = hi;
                sum = (hi ? 9'h060 : 9'h000) + (lo ? 9'h006 : 9'h000);
            end
            m_adj  = sum[7:0];
            m_busy = 1'b1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 1'b0; alu_c = 1'b0; alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0;
        alu_hc = 1'b0; alu_dhc = 1'b0; alu_dc = 1'b0; db = 8'h00; upd = 4'd0;
        b_in = 1'b1; dec_go = 1'b0; sub = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (p_out !== 8'h34) begin errors++; $display("FAIL reset_p_b1: got %h want %h", p_out, 8'h34); end
        checks++; if (adj_out !== 8'h00) begin errors++; $display("FAIL reset_adj: got %h want 00", adj_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        b_in = 1'b0;
        #1;
        checks++; if (p_out !== 8'h24) begin errors++; $display("FAIL reset_p_b0: got %h want %h", p_out, 8'h24); end
        b_in = 1'b1;
    endtask

    task automatic test_adc_simple();
        logic [7:0] res;
        clear_inputs(); upd = 4'd11; step();
        // 0x19 + 0x28 binary = 0x41, half carry out of bit 3
        alu_hc = 1'b1; dec_go = 1'b1; upd = 4'd3;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL adc1_busy: got %b want 1", busy); end
        checks++; if (adj_out !== 8'h06) begin errors++; $display("FAIL adc1_adj: got %h want 06", adj_out); end
        res = 8'h41 + adj_out;
        checks++; if (res !== 8'h47) begin errors++; $display("FAIL adc1_result: got %h want 47", res); end
        clear_inputs(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL adc1_done: got %b want 0", busy); end
        checks++; if (p_out[0] !== 1'b0) begin errors++; $display("FAIL adc1_c: got %b want 0", p_out[0]); end
        checks++; if (adj_out !== 8'h00) begin errors++; $display("FAIL adc1_adj_idle: got %h want 00", adj_out); end
    endtask

    task automatic test_adc_carry();
        logic [7:0] res;
        // 0x99 + 0x01 binary = 0x9A
        clear_inputs();
        alu_n = 1'b1; alu_dhc = 1'b1; alu_dc = 1'b1; dec_go = 1'b1; upd = 4'd3;
        step();
        checks++; if (adj_out !== 8'h66) begin errors++; $display("FAIL adc2_adj: got %h want 66", adj_out); end
        res = 8'h9A + adj_out;
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL adc2_result: got %h want 00", res); end
        clear_inputs(); step();
        checks++; if (p_out[0] !== 1'b1) begin errors++; $display("FAIL adc2_c: got %b want 1", p_out[0]); end
        checks++; if (p_out[7] !== 1'b1 || p_out[1] !== 1'b0) begin errors++; $display("FAIL adc2_nz: got N=%b Z=%b want N=1 Z=0", p_out[7], p_out[1]); end
    endtask

    task automatic test_sbc();
        logic [7:0] res;
        clear_inputs(); upd = 4'd7; step();
        // 0x40 - 0x01 with C=1: binary 0x3F, borrow from low nibble, no byte borrow
        alu_c = 1'b1; sub = 1'b1; dec_go = 1'b1; upd = 4'd3;
        step();
        checks++; if (busy !== 1'b1 || adj_out !== 8'hFA) begin errors++; $display("FAIL sbc_adj: got busy=%b adj=%h want busy=1 adj=fa", busy, adj_out); end
        res = 8'h3F + adj_out;
        checks++; if (res !== 8'h39) begin errors++; $display("FAIL sbc_result: got %h want 39", res); end
        clear_inputs(); step();
        checks++; if (p_out[0] !== 1'b1) begin errors++; $display("FAIL sbc_c: got %b want 1", p_out[0]); end
        upd = 4'd10; step();
        checks++; if (d_out !== 1'b0) begin errors++; $display("FAIL cld: got %b want 0", d_out); end
        clear_inputs();
        alu_c = 1'b1; sub = 1'b1; dec_go = 1'b1; upd = 4'd3;
        step();
        checks++; if (busy !== 1'b0 || adj_out !== 8'h00) begin errors++; $display("FAIL sbc_bin_busy: got busy=%b adj=%h want 0/00", busy, adj_out); end
        checks++; if (p_out[0] !== 1'b1) begin errors++; $display("FAIL sbc_bin_c: got %b want 1", p_out[0]); end
    endtask

    task automatic test_plp_bit();
        clear_inputs();
        upd = 4'd5; db = 8'hFF; step();
        checks++; if (p_out !== 8'hFF) begin errors++; $display("FAIL plp: got %h want ff", p_out); end
        upd = 4'd4; db = 8'hC0; alu_z = 1'b1; step();
        checks++; if (p_out !== 8'hFF) begin errors++; $display("FAIL bit: got %h want ff", p_out); end
        clear_inputs(); upd = 4'd6; step();
        checks++; if (p_out !== 8'hFE) begin errors++; $display("FAIL clc: got %h want fe", p_out); end
    endtask

    task automatic test_adj_override();
        // D=1, C=0 left by the previous scenario
        clear_inputs();
        alu_c = 1'b1; alu_z = 1'b1; dec_go = 1'b1; upd = 4'd3;
        step();
        checks++; if (busy !== 1'b1 || adj_out !== 8'h60) begin errors++; $display("FAIL ovr_start: got busy=%b adj=%h want 1/60", busy, adj_out); end
        clear_inputs();
        upd = 4'd2; alu_c = 1'b0; alu_n = 1'b1; alu_z = 1'b0; dec_go = 1'b1;
        step();
        checks++; if (p_out[7] !== 1'b1 || p_out[1] !== 1'b0 || p_out[0] !== 1'b1) begin
            errors++; $display("FAIL ovr_flags: got N=%b Z=%b C=%b want 1 0 1", p_out[7], p_out[1], p_out[0]);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_ignore_go: got busy=%b want 0", busy); end
        clear_inputs();
        alu_c = 1'b1; dec_go = 1'b1; upd = 4'd6;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_adj_start: got %b want 1", busy); end
        clear_inputs(); reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (p_out !== 8'h34 || busy !== 1'b0 || adj_out !== 8'h00) begin
            errors++; $display("FAIL rst_mid_adj: got P=%h busy=%b adj=%h want 34/0/00", p_out, busy, adj_out);
        end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int k = 0; k < 800; k++) begin
            reset   = ($urandom_range(0, 40) == 0);
            alu_c   = 1'($urandom); alu_n  = 1'($urandom); alu_z   = 1'($urandom);
            alu_v   = 1'($urandom); alu_hc = 1'($urandom); alu_dhc = 1'($urandom);
            alu_dc  = 1'($urandom); db     = 8'($urandom); upd     = 4'($urandom);
            b_in    = 1'($urandom); dec_go = 1'($urandom); sub     = 1'($urandom);
            step();
            checks++; if (p_out !== model_p()) begin errors++; $display("FAIL rnd_p[%0d]: got %h want %h", k, p_out, model_p()); end
            checks++; if (adj_out !== m_adj) begin errors++; $display("FAIL rnd_adj[%0d]: got %h want %h", k, adj_out, m_adj); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, busy, m_busy); end
            checks++; if (d_out !== m_p[3]) begin errors++; $display("FAIL rnd_d[%0d]: got %b want %b", k, d_out, m_p[3]); end
        end
    endtask

    initial begin
        test_reset();
        test_adc_simple();
        test_adc_carry();
        test_sbc();
        test_plp_bit();
        test_adj_override();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
